// File: rtl/fetch_sequencer.sv
// Multicycle instruction-fetch stage: owns the program counter, reads one word
// per instruction through a req/ack handshake with timeout, and holds it in ir.
module fetch_sequencer #(
  parameter int unsigned          ADDR_W     = 24,
  parameter int unsigned          DATA_W     = 24,
  parameter logic [ADDR_W-1:0]    RESET_PC   = '0,
  parameter int unsigned          WAIT_LIMIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              ir_taken,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              fault,
  output logic              busy
);

  // A limit of 1 still needs a 1-bit timer so the compare below stays legal.
  localparam int unsigned TW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(WAIT_LIMIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;

  assign pc_plus1 = pc + 1'b1;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      ir       <= '0;
      ir_valid <= 1'b0;
      fault    <= 1'b0;
      timer    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            fault <= 1'b0;
            state <= FETCH;
          end
        end

        FETCH: begin
          mem_addr <= pc;
          mem_rd   <= 1'b1;
          timer    <= '0;
          state    <= WAIT;
        end

        WAIT: begin
          // An ack on the final allowed edge wins over the timeout.
          if (mem_ack) begin
            ir       <= mem_rdata;
            ir_valid <= 1'b1;
            mem_rd   <= 1'b0;
            pc       <= pc_plus1;
            state    <= HOLD;
          end else if (timer == TIMER_LAST) begin
            fault  <= 1'b1;
            mem_rd <= 1'b0;
            state  <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        HOLD: begin
          if (ir_taken) begin
            ir_valid <= 1'b0;
            if (branch_en) pc <= branch_target;
            state <= halt ? IDLE : FETCH;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
